// File: rtl/sys_pkg.sv
// Shared constants and the drain FSM state type for the systolic drain block.
package sys_pkg;

    localparam int SYS_WIDTH = 8;
    localparam int SYS_ROW   = 3;
    localparam int SYS_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } drain_state_e;

endpackage

// File: rtl/sys_drain_fifo.sv
// Vector FIFO with fall-through read: a word written at edge N is on rdata right after N.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module sys_drain_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en;
    logic              rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    // Gate with empty so the output reads zero after reset without clearing the array.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/systolic_drain.sv
// De-skews a systolic result vector and collects num_vec aligned vectors into an output FIFO.
// Optional macro SYS_DRAIN_RELU_EN clamps negative (signed) lanes to zero before the FIFO.
module systolic_drain
    import sys_pkg::*;
#(
    parameter int WIDTH = SYS_WIDTH,
    parameter int ROW   = SYS_ROW,
    parameter int DEPTH = SYS_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [15:0]                num_vec,
    input  logic                       in_valid,
    input  logic [ROW-1:0][WIDTH-1:0]  feature_in,
    output logic [ROW*WIDTH-1:0]       out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow
);

    logic [ROW*WIDTH-1:0] push_data;
    logic                 aligned_valid;

    drain_state_e state_q, state_d;
    logic [15:0]  count_q, count_d;
    logic [15:0]  num_vec_q, num_vec_d;
    logic [15:0]  count_inc;
    logic         ovf_q, ovf_d;
    logic         push_req;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;

    // Lane-0 valid travels the longest path, ROW-1 stages.
    if (ROW == 1) begin : g_vld_pass
        assign aligned_valid = in_valid;
    end else begin : g_vld
        logic [ROW-2:0] vld_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= in_valid;
                for (int k = 1; k < ROW - 1; k++) vld_q[k] <= vld_q[k-1];
            end
        end
        assign aligned_valid = vld_q[ROW-2];
    end

    for (genvar gi = 0; gi < ROW; gi++) begin : g_lane
        localparam int STAGES = ROW - 1 - gi;
        logic [WIDTH-1:0] lane_aligned;

        if (STAGES == 0) begin : g_pass
            assign lane_aligned = feature_in[gi];
        end else begin : g_dly
            logic [WIDTH-1:0] dly_q [STAGES];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < STAGES; k++) dly_q[k] <= '0;
                end else begin
                    dly_q[0] <= feature_in[gi];
                    for (int k = 1; k < STAGES; k++) dly_q[k] <= dly_q[k-1];
                end
            end
            assign lane_aligned = dly_q[STAGES-1];
        end

`ifdef SYS_DRAIN_RELU_EN
        assign push_data[gi*WIDTH +: WIDTH] = lane_aligned[WIDTH-1] ? '0 : lane_aligned;
`else
        assign push_data[gi*WIDTH +: WIDTH] = lane_aligned;
`endif
    end

    assign push_req  = aligned_valid && (state_q == ST_COLLECT);
    assign fifo_pop  = out_valid && out_ready;
    assign count_inc = count_q + 16'd1;
    assign out_valid = !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = (num_vec == 16'd0) ? ST_DONE : ST_COLLECT;
            ST_COLLECT: if (push_req && (count_inc == num_vec_q)) state_d = ST_FLUSH;
            ST_FLUSH:   if (fifo_empty) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_COLLECT) || (state_q == ST_FLUSH);
        done = (state_q == ST_DONE);
    end

    // A dropped vector still counts toward num_vec so the run always terminates.
    always_comb begin
        count_d   = count_q;
        num_vec_d = num_vec_q;
        ovf_d     = ovf_q;
        if ((state_q == ST_IDLE) && start) begin
            count_d   = '0;
            num_vec_d = num_vec;
            ovf_d     = 1'b0;
        end else if (push_req) begin
            count_d = count_inc;
            if (fifo_full && !fifo_pop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            num_vec_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            num_vec_q <= num_vec_d;
            ovf_q     <= ovf_d;
        end
    end

    assign overflow = ovf_q;

    sys_drain_fifo #(
        .DATA_W (ROW*WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (fifo_pop),
        .wdata (push_data),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 SHALL have parameter WIDTH, default 8, lane data width in bits.
REQ-002 SHALL have parameter ROW, default 3, number of lanes (PEs per systolic vector).
REQ-003 SHALL have parameter DEPTH, default 4, output FIFO depth in vectors (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a collection run.
REQ-007 SHALL have port num_vec  input  16  number of vectors to collect in the run, sampled on start.
REQ-008 SHALL have port in_valid  input  1  lane-0 data valid; lane i is valid i cycles later.
REQ-009 SHALL have port feature_in  input  [WIDTH-1:0] x ROW  skewed per-lane results from the systolic vector.
REQ-010 SHALL have port out_data  output  ROW*WIDTH  aligned vector; lane i is in bits [i*WIDTH +: WIDTH].
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-013 SHALL have ports busy, done, overflow  output  1 each  run active / one-cycle completion pulse / sticky drop flag.

Function
REQ-014 SHALL de-skew by delaying lane i by ROW-1-i register stages and in_valid by ROW-1 stages, so an aligned vector is formed ROW-1 cycles after its lane-0 in_valid.
REQ-015 SHALL implement FSM IDLE, COLLECT, FLUSH, DONE.
REQ-016 IDLE->COLLECT on start with num_vec!=0; IDLE->DONE on start with num_vec==0; start outside IDLE SHALL be ignored.
REQ-017 In COLLECT, each aligned valid vector SHALL be pushed to the FIFO and increment a 16-bit counter; counter==num_vec SHALL transition to FLUSH.
REQ-018 In IDLE, FLUSH and DONE, aligned vectors SHALL be discarded and not counted.
REQ-019 A push while the FIFO is full SHALL drop the vector, still count it, and set overflow; overflow SHALL clear only on rst or start.
REQ-020 A push and a pop in the same cycle on a full FIFO SHALL both succeed (no overflow).
REQ-021 FLUSH->DONE when the FIFO is empty; DONE SHALL last exactly one cycle, then go to IDLE.
REQ-022 done SHALL be high only in DONE; busy SHALL be high in COLLECT and FLUSH.
REQ-023 out_valid SHALL equal FIFO not-empty; a pop SHALL occur when out_valid and out_ready; out_data SHALL be stable while out_valid and not out_ready.
REQ-024 FIFO latency SHALL be one cycle: a vector pushed at edge N is visible on out_data after edge N.

Reset
REQ-025 rst SHALL asynchronously force FSM IDLE, counter 0, FIFO empty, all de-skew valid stages 0, out_valid 0, busy 0, done 0, overflow 0; out_data 0.
REQ-026 rst mid-run SHALL abandon the run; no done pulse SHALL follow deassertion.

Configuration
REQ-027 With macro SYS_DRAIN_RELU_EN defined, each lane SHALL be treated as signed and negative values replaced by 0 before the FIFO push.
REQ-028 Without SYS_DRAIN_RELU_EN, lanes SHALL pass unmodified.

Structure
REQ-029 Package sys_pkg SHALL hold default WIDTH/ROW constants and the drain FSM state enum typedef.
REQ-030 The FIFO SHALL be a sub-module named sys_drain_fifo (parameters WIDTH*ROW, DEPTH; push/pop/full/empty).

Verification
REQ-031 ROW=3, num_vec=2, lane i given value 10*k+i at cycle k+i for k=0,1, out_ready=1 -> out_data lanes {0,1,2} then {10,11,12}, done pulse once, overflow 0.
REQ-032 start with num_vec=0 -> done high on the next cycle for one cycle, busy never high, out_valid 0.
REQ-033 DEPTH=4, num_vec=6, out_ready=0 -> 4 vectors held, overflow=1, FSM stays FLUSH until out_ready=1 drains 4 vectors, then done.
REQ-034 FIFO full with simultaneous push and pop -> overflow stays 0, ordering preserved.
REQ-035 rst asserted in COLLECT after 1 of 3 vectors -> all outputs 0 immediately; new start with num_vec=1 completes normally.
REQ-036 With SYS_DRAIN_RELU_EN, WIDTH=8, lane value 8'hF0 -> output lane 0; 8'h70 -> 8'h70; without macro 8'hF0 passes.
